pe_bps_column_feeder: RTL and testbench

- Transmitter for the combined-B/partial-sum PE column interface (load_B, A, shared_B_PS).
- Accepts B weights and an A stream over valid/ready, then sequences one column of rows_p PEs:
  - B-load phase: load_B=1, B sign-extended onto the shared bus.
  - Compute phase: load_B=0, A streamed, bus driven with zero partial-sum seed.
  - Flush phase: drains the column.
- Sits at the top/left edge of the torus systolic array, one instance per column.

---
 rtl/pe_bps_column_feeder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pe_bps_column_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_bps_column_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pe_bps_column_feeder
//  Purpose  : Column transmitter for the combined B / partial-sum PE interface.
//             Accepts B weights and an A stream over valid/ready and sequences
//             one column of ROWS_P PEs.
//             - LOAD_B : load_B=1, B sign-extended onto the shared bus.
//             - STREAM : A streamed, bus carries a zero partial-sum seed.
//             - FLUSH  : ROWS_P empty cycles drain the column.
//             - DONE   : one-cycle done_o pulse.
//  Options  : PE_FEEDER_SKID_EN adds a 2-entry skid buffer on the A input.
//             A is then accepted whenever the job still needs elements and an
//             entry is free, which allows pre-fill during LOAD_B.
//  Revision : 1.0  initial release
// ============================================================================
module pe_bps_column_feeder #(
    parameter int ROWS_P      = 4,
    parameter int A_WIDTH_P   = 8,
    parameter int PS_WIDTH_P  = 16,
    parameter int LEN_WIDTH_P = 8
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [LEN_WIDTH_P-1:0] num_a_i,
    input  logic                   b_v_i,
    input  logic [A_WIDTH_P-1:0]   b_data_i,
    output logic                   b_ready_o,
    input  logic                   a_v_i,
    input  logic [A_WIDTH_P-1:0]   a_data_i,
    output logic                   a_ready_o,
    output logic                   load_B,
    output logic [A_WIDTH_P-1:0]   A_out,
    output logic [PS_WIDTH_P-1:0]  shared_B_PS_out,
    output logic                   out_v_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                     c_CNT_W     = $clog2(ROWS_P + 1);
    localparam int                     c_EXT_W     = PS_WIDTH_P - A_WIDTH_P;
    localparam logic [c_CNT_W-1:0]     c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]     c_ROWS_LAST = c_CNT_W'(ROWS_P - 1);
    localparam logic [c_CNT_W-1:0]     c_ROWS_CNT  = c_CNT_W'(ROWS_P);
    localparam logic [LEN_WIDTH_P-1:0] c_LEN_ONE   = LEN_WIDTH_P'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_B = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_next_state;

    logic [c_CNT_W-1:0]      r_b_cnt;
    logic [c_CNT_W-1:0]      r_fl_cnt;
    logic [LEN_WIDTH_P-1:0]  r_a_cnt;
    logic [LEN_WIDTH_P-1:0]  r_num_a;

    logic                    r_b_ready;
    logic                    r_a_ready;
    logic                    r_load_b;
    logic [PS_WIDTH_P-1:0]   r_bus;
    logic [A_WIDTH_P-1:0]    r_a_out;
    logic                    r_out_v;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_start;
    logic                    w_b_xfer;
    logic                    w_a_xfer;
    logic [A_WIDTH_P-1:0]    w_a_data;
    logic                    w_b_last;
    logic                    w_a_last;
    logic                    w_fl_last;
    logic [PS_WIDTH_P-1:0]   w_b_ext;

    // ------------------------------------------------------------------------
    // Handshake and terminal-count decode
    // ------------------------------------------------------------------------
    assign w_start   = (r_state == S_IDLE) && start_i;
    assign w_b_xfer  = b_v_i && r_b_ready;
    assign w_b_last  = w_b_xfer && (r_b_cnt == c_ROWS_LAST);
    assign w_a_last  = w_a_xfer && (r_a_cnt == (r_num_a - c_LEN_ONE));
    assign w_fl_last = (r_fl_cnt == c_ROWS_LAST);
    // B is a signed weight; widen to the bus with its sign bit replicated.
    assign w_b_ext   = {{c_EXT_W{b_data_i[A_WIDTH_P-1]}}, b_data_i};

`ifdef PE_FEEDER_SKID_EN
    // ------------------------------------------------------------------------
    // A-input skid buffer: two entries, ready driven from occupancy and the
    // number of elements the current job still needs.
    // ------------------------------------------------------------------------
    logic [A_WIDTH_P-1:0]    r_skid_mem [2];
    logic                    r_skid_wr;
    logic                    r_skid_rd;
    logic [1:0]              r_skid_cnt;
    logic [1:0]              w_skid_cnt_nxt;
    logic [LEN_WIDTH_P-1:0]  r_acc_cnt;
    logic [LEN_WIDTH_P-1:0]  w_acc_nxt;
    logic [LEN_WIDTH_P-1:0]  w_limit_nxt;
    logic                    w_push;
    logic                    w_pop;

    assign w_push   = a_v_i && r_a_ready;
    assign w_pop    = (r_state == S_STREAM) && (r_skid_cnt != 2'd0);
    assign w_a_xfer = w_pop;
    assign w_a_data = r_skid_mem[r_skid_rd];

    // Next occupancy and per-job acceptance tally feeding the ready flop
    always_comb begin
        w_skid_cnt_nxt = r_skid_cnt + {1'b0, w_push} - {1'b0, w_pop};
        w_acc_nxt      = w_start ? '0 : (r_acc_cnt + {{(LEN_WIDTH_P-1){1'b0}}, w_push});
        w_limit_nxt    = w_start ? num_a_i : r_num_a;
    end

    // Skid storage; contents are qualified by the occupancy count
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_skid_mem[r_skid_wr] <= a_data_i;
        end
    end

    // Skid pointers, occupancy, acceptance tally and registered ready
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_skid_wr  <= 1'b0;
            r_skid_rd  <= 1'b0;
            r_skid_cnt <= 2'd0;
            r_acc_cnt  <= '0;
            r_a_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_skid_wr <= ~r_skid_wr;
            end
            if (w_pop) begin
                r_skid_rd <= ~r_skid_rd;
            end
            r_skid_cnt <= w_skid_cnt_nxt;
            r_acc_cnt  <= w_acc_nxt;
            r_a_ready  <= (w_skid_cnt_nxt != 2'd2) && (w_acc_nxt < w_limit_nxt);
        end
    end
`else
    // ------------------------------------------------------------------------
    // Direct A input: ready only while streaming, one-cycle latency.
    // ------------------------------------------------------------------------
    assign w_a_xfer = a_v_i && r_a_ready;
    assign w_a_data = a_data_i;

    // A ready is a flop of the next-state decode
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_a_ready <= 1'b0;
        end else begin
            r_a_ready <= (w_next_state == S_STREAM);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (w_b_last) begin
                    w_next_state = (r_num_a == '0) ? S_FLUSH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_a_last) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_fl_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Job length latch and B / A / flush counters (saturating, no wrap)
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_num_a  <= '0;
            r_b_cnt  <= '0;
            r_a_cnt  <= '0;
            r_fl_cnt <= '0;
        end else begin
            if (w_start) begin
                r_num_a <= num_a_i;
                r_b_cnt <= '0;
                r_a_cnt <= '0;
            end else begin
                if (w_b_xfer && (r_b_cnt != c_ROWS_CNT)) begin
                    r_b_cnt <= r_b_cnt + c_CNT_ONE;
                end
                if (w_a_xfer && (r_a_cnt != r_num_a)) begin
                    r_a_cnt <= r_a_cnt + c_LEN_ONE;
                end
            end
            r_fl_cnt <= ((r_state == S_FLUSH) && !w_fl_last) ? (r_fl_cnt + c_CNT_ONE) : '0;
        end
    end

    // Registered column outputs, status and B ready
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_b_ready <= 1'b0;
            r_load_b  <= 1'b0;
            r_bus     <= '0;
            r_a_out   <= '0;
            r_out_v   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_b_ready <= (w_next_state == S_LOAD_B);
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
            r_load_b  <= w_b_xfer;
            r_out_v   <= w_a_xfer;
            r_a_out   <= w_a_xfer ? w_a_data : '0;
            // Bus carries B while loading, otherwise the zero partial-sum seed
            r_bus     <= w_b_xfer ? w_b_ext : '0;
        end
    end

    assign b_ready_o       = r_b_ready;
    assign a_ready_o       = r_a_ready;
    assign load_B          = r_load_b;
    assign A_out           = r_a_out;
    assign shared_B_PS_out = r_bus;
    assign out_v_o         = r_out_v;
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pe_bps_column_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_bps_column_feeder
//  Purpose  : Self-checking bench for pe_bps_column_feeder (default build).
//             A job-level model predicts every output each cycle; directed
//             jobs add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_bps_column_feeder;

    localparam int R = 4;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [7:0]  num_a_i;
    logic        b_v_i;
    logic [7:0]  b_data_i;
    logic        b_ready_o;
    logic        a_v_i;
    logic [7:0]  a_data_i;
    logic        a_ready_o;
    logic        load_B;
    logic [7:0]  A_out;
    logic [15:0] shared_B_PS_out;
    logic        out_v_o;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    pe_bps_column_feeder #(
        .ROWS_P      (4),
        .A_WIDTH_P   (8),
        .PS_WIDTH_P  (16),
        .LEN_WIDTH_P (8)
    ) dut (
        .clk_i           (clk),
        .reset           (reset),
        .start_i         (start_i),
        .num_a_i         (num_a_i),
        .b_v_i           (b_v_i),
        .b_data_i        (b_data_i),
        .b_ready_o       (b_ready_o),
        .a_v_i           (a_v_i),
        .a_data_i        (a_data_i),
        .a_ready_o       (a_ready_o),
        .load_B          (load_B),
        .A_out           (A_out),
        .shared_B_PS_out (shared_B_PS_out),
        .out_v_o         (out_v_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Stimulus words and literal expectations
    logic [7:0]  bw      [4] = '{8'h05, 8'hFE, 8'h7F, 8'h80};
    logic [15:0] exp_bus [4] = '{16'h0005, 16'hFFFE, 16'h007F, 16'hFF80};
    logic [7:0]  exp_a   [3] = '{8'd1, 8'd2, 8'd3};

    // Observations collected per job
    logic [15:0] q_bus[$];
    logic [7:0]  q_a[$];
    bit          aready_seen;
    int          done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {2'b00, load_B, shared_B_PS_out, A_out, out_v_o, busy_o, done_o, b_ready_o, a_ready_o};
    endfunction

    // ------------------------------------------------------------------------
    // Job-level model: a job owns R B-words, num A-elements, R flush cycles
    // and one done cycle.  Inputs are stable at the falling edge and are what
    // the next rising edge samples.
    // ------------------------------------------------------------------------
    int          m_job = 0, m_bn = 0, m_an = 0, m_fl = 0, m_num = 0;
    bit          armed = 0;
    logic        e_load = 0, e_v = 0;
    logic [15:0] e_bus = 0;
    logic [7:0]  e_a = 0;

    initial begin
        bit in_load, in_str, in_fl, in_done;
        int s;
        forever begin
            @(negedge clk);
            in_load = (m_job != 0) && (m_bn < R);
            in_str  = (m_job != 0) && (m_bn >= R) && (m_an < m_num);
            in_fl   = (m_job != 0) && (m_bn >= R) && (m_an >= m_num) && (m_fl < R);
            in_done = (m_job != 0) && (m_bn >= R) && (m_an >= m_num) && (m_fl >= R);
            if (armed) begin
                check("cycle_outputs", outs(),
                      {2'b00, e_load, e_bus, e_a, e_v, (m_job != 0), in_done, in_load, in_str});
                if (load_B)    q_bus.push_back(shared_B_PS_out);
                if (out_v_o)   q_a.push_back(A_out);
                if (a_ready_o) aready_seen = 1;
                if (done_o)    done_cnt++;
            end
            e_load = 0; e_bus = 0; e_a = 0; e_v = 0;
            if (reset) begin
                m_job = 0; m_bn = 0; m_an = 0; m_fl = 0;
                armed = 1;
            end else if (in_load) begin
                if (b_v_i) begin
                    e_load = 1;
                    s = $signed(b_data_i);
                    e_bus = s[15:0];
                    m_bn++;
                end
            end else if (in_str) begin
                if (a_v_i) begin
                    e_v = 1;
                    e_a = a_data_i;
                    m_an++;
                end
            end else if (in_fl) begin
                m_fl++;
            end else if (in_done) begin
                m_job = 0;
            end else if (start_i) begin
                m_job = 1; m_num = int'(num_a_i); m_bn = 0; m_an = 0; m_fl = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Job driver.  cyc counts the start cycle as 1 and reports the cycle in
    // which done_o is seen.
    // ------------------------------------------------------------------------
    task automatic run_job(input int num, input int bstall, input int astall,
                           input bit hold_b, input int restart_at, input bit abort,
                           output int cyc);
        int bi, ai, bs, as_;
        bit hb, ha, fin, aborted;
        bi = 0; ai = 0; bs = 0; as_ = 0; cyc = 0; fin = 0; aborted = 0;
        q_bus.delete(); q_a.delete(); aready_seen = 0; done_cnt = 0;
        @(posedge clk); #1;
        start_i = 1; num_a_i = 8'(num);
        for (int n = 1; n <= 400 && !fin && !aborted; n++) begin
            if (bi < R) begin
                if (bi == bstall && bs < 2) begin
                    b_v_i = 0; bs++;
                end else begin
                    b_v_i = 1; b_data_i = bw[bi];
                end
            end else begin
                b_v_i = hold_b; b_data_i = 8'h33;
            end
            if (ai < num) begin
                if (ai == astall && as_ < 1) begin
                    a_v_i = 0; as_++;
                end else begin
                    a_v_i = 1; a_data_i = 8'(ai + 1);
                end
            end else begin
                a_v_i = 0;
            end
            @(negedge clk);
            if (done_o) begin
                cyc = n; fin = 1;
            end else begin
                hb = b_v_i && b_ready_o;
                ha = a_v_i && a_ready_o;
                @(posedge clk); #1;
                start_i = (n + 1 == restart_at);
                if (hb) bi++;
                if (ha) ai++;
                if (abort && ai == 2) begin
                    reset = 1; b_v_i = 0; a_v_i = 0; start_i = 0;
                    @(posedge clk); #1;
                    reset = 0;
                    check("reset_mid_outputs", outs(), 32'h0);
                    done_cnt = 0;
                    repeat (6) @(negedge clk);
                    check("reset_mid_no_done", done_cnt, 0);
                    aborted = 1;
                end
            end
        end
        if (!fin && !aborted) begin
            total++; bad++;
            $display("FAIL job_timeout: no done_o within 400 cycles (num_a=%0d)", num);
        end
        @(posedge clk); #1;
        start_i = 0; b_v_i = 0; a_v_i = 0;
    endtask

    task automatic check_words(input string tag, input int na);
        check({tag, "_b_count"}, q_bus.size(), 4);
        for (int i = 0; i < 4; i++)
            check({tag, "_b_word"}, (i < q_bus.size()) ? 32'(q_bus[i]) : 32'hDEAD, 32'(exp_bus[i]));
        check({tag, "_a_count"}, q_a.size(), na);
        for (int i = 0; i < na; i++)
            check({tag, "_a_word"}, (i < q_a.size()) ? 32'(q_a[i]) : 32'hDEAD, 32'(exp_a[i]));
    endtask

    initial begin
        int cyc;
        reset = 1; start_i = 0; num_a_i = 0;
        b_v_i = 0; b_data_i = 0; a_v_i = 0; a_data_i = 0;
        repeat (5) @(posedge clk);
        #1 reset = 0;
        check("reset_outputs", outs(), 32'h0);
        repeat (2) @(posedge clk); #1;

        // Basic job; start re-asserted in the DONE cycle must be ignored
        run_job(3, -1, -1, 0, 13, 0, cyc);
        check("basic_cycles", cyc, 13);
        check_words("basic", 3);
        @(negedge clk);
        check("restart_in_done_ignored", busy_o, 0);
        repeat (2) @(posedge clk); #1;

        // Stalls: B valid dropped 2 cycles on word 2, A valid dropped once
        run_job(3, 1, 1, 0, 0, 0, cyc);
        check("stall_cycles", cyc, 16);
        check_words("stall", 3);
        repeat (2) @(posedge clk); #1;

        // Zero-length job
        run_job(0, -1, -1, 0, 0, 0, cyc);
        check("zero_cycles", cyc, 10);
        check("zero_a_ready_never", aready_seen, 0);
        check_words("zero", 0);
        repeat (2) @(posedge clk); #1;

        // Out-of-phase valids: A offered during LOAD_B, B held during STREAM
        run_job(2, -1, -1, 1, 0, 0, cyc);
        check("oop_cycles", cyc, 12);
        check_words("oop", 2);
        repeat (2) @(posedge clk); #1;

        // Reset after the second A element, then a normal one-element job
        run_job(3, -1, -1, 0, 0, 1, cyc);
        repeat (2) @(posedge clk); #1;
        run_job(1, -1, -1, 0, 0, 0, cyc);
        check("after_reset_cycles", cyc, 11);
        check_words("after_reset", 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
